// File: rtl/icache_uart_loader.sv
// UART-side sequencer for the instruction cache BRAM: loads all lines from a host
// byte stream, dumps them back through the transmitter, and gates CPU execution.
module icache_uart_loader #(
    parameter int unsigned NUM_LINES = 64,
    parameter logic [7:0]  CMD_LOAD  = 8'hA5,
    parameter logic [7:0]  CMD_DUMP  = 8'h5A
) (
    input  logic         Clk,
    input  logic         Resetb,
    input  logic         Rx_Valid,
    input  logic [7:0]   Rx_Data,
    input  logic         Tx_Ready,
    output logic         Tx_Valid,
    output logic [7:0]   Tx_Data,
    input  logic [127:0] InstCache_BackData,
    output logic         Cache_Init,
    output logic         Send_DataBack,
    output logic         Uart_InstCache_WE,
    output logic [5:0]   Uart_Cache_InitAddr,
    output logic [127:0] Uart_Cache_InitData,
    output logic [5:0]   Uart_InstCache_RdAddr,
    output logic         Cpu_Run,
    output logic         Rx_Ovr_Err
);

    localparam int unsigned AW = 6;
    localparam int unsigned LW = 128;
    localparam logic [AW-1:0] LAST_LINE = AW'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_TX
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] line_q, line_d;
    logic [3:0]    rx_cnt_q, rx_cnt_d;
    logic [3:0]    tx_cnt_q, tx_cnt_d;
    logic [LW-1:0] asm_q, asm_d;
    logic [LW-1:0] tx_shift_q, tx_shift_d;
    logic          loaded_q, loaded_d;
    logic          we_q, we_d;
    logic [AW-1:0] init_addr_q, init_addr_d;
    logic [LW-1:0] init_data_q, init_data_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          cache_init_q, cache_init_d;
    logic          send_back_q, send_back_d;
    logic          tx_valid_q, tx_valid_d;
    logic          cpu_run_q, cpu_run_d;
    logic          ovr_q, ovr_d;
    logic          in_dump;

    // State and datapath registers; reset aborts any load or dump immediately
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            asm_q        <= '0;
            tx_shift_q   <= '0;
            loaded_q     <= 1'b0;
            we_q         <= 1'b0;
            init_addr_q  <= '0;
            init_data_q  <= '0;
            rd_addr_q    <= '0;
            cache_init_q <= 1'b0;
            send_back_q  <= 1'b0;
            tx_valid_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            asm_q        <= asm_d;
            tx_shift_q   <= tx_shift_d;
            loaded_q     <= loaded_d;
            we_q         <= we_d;
            init_addr_q  <= init_addr_d;
            init_data_q  <= init_data_d;
            rd_addr_q    <= rd_addr_d;
            cache_init_q <= cache_init_d;
            send_back_q  <= send_back_d;
            tx_valid_q   <= tx_valid_d;
            cpu_run_q    <= cpu_run_d;
            ovr_q        <= ovr_d;
        end
    end

    assign in_dump = (state_q == S_DUMP_RD) || (state_q == S_DUMP_CAP) || (state_q == S_DUMP_TX);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        rx_cnt_d    = rx_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        asm_d       = asm_q;
        tx_shift_d  = tx_shift_q;
        loaded_d    = loaded_q;
        we_d        = 1'b0;
        init_addr_d = init_addr_q;
        init_data_d = init_data_q;
        rd_addr_d   = rd_addr_q;
        ovr_d       = ovr_q || (Rx_Valid && in_dump);

        case (state_q)
            S_IDLE: begin
                if (Rx_Valid && (Rx_Data == CMD_LOAD)) begin
                    state_d  = S_LOAD;
                    line_d   = '0;
                    rx_cnt_d = '0;
                    loaded_d = 1'b0;
                end else if (Rx_Valid && (Rx_Data == CMD_DUMP)) begin
                    state_d   = S_DUMP_RD;
                    line_d    = '0;
                    rd_addr_d = '0;
                end
            end
            S_LOAD: begin
                if (Rx_Valid) begin
                    // New byte enters at the top so the first byte ends up in [7:0]
                    asm_d    = {Rx_Data, asm_q[LW-1:8]};
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'hF) begin
                        we_d        = 1'b1;
                        init_addr_d = line_q;
                        init_data_d = {Rx_Data, asm_q[LW-1:8]};
                        if (line_q == LAST_LINE) begin
                            state_d  = S_IDLE;
                            loaded_d = 1'b1;
                        end else begin
                            line_d = line_q + AW'(1);
                        end
                    end
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                tx_shift_d = InstCache_BackData;
                tx_cnt_d   = '0;
                state_d    = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                if (tx_valid_q && Tx_Ready) begin
                    tx_shift_d = {8'h00, tx_shift_q[LW-1:8]};
                    tx_cnt_d   = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'hF) begin
                        if (line_q == LAST_LINE) begin
                            state_d = S_IDLE;
                        end else begin
                            line_d    = line_q + AW'(1);
                            rd_addr_d = line_q + AW'(1);
                            state_d   = S_DUMP_RD;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cache_Init covers the final WE cycle; Cpu_Run waits one cycle past it
        cache_init_d = (state_d == S_LOAD) || we_d;
        send_back_d  = (state_d == S_DUMP_RD) || (state_d == S_DUMP_CAP) || (state_d == S_DUMP_TX);
        tx_valid_d   = (state_d == S_DUMP_TX);
        cpu_run_d    = loaded_d && (state_d == S_IDLE) && !we_d;
    end

    assign Tx_Valid              = tx_valid_q;
    assign Tx_Data               = tx_shift_q[7:0];
    assign Cache_Init            = cache_init_q;
    assign Send_DataBack         = send_back_q;
    assign Uart_InstCache_WE     = we_q;
    assign Uart_Cache_InitAddr   = init_addr_q;
    assign Uart_Cache_InitData   = init_data_q;
    assign Uart_InstCache_RdAddr = rd_addr_q;
    assign Cpu_Run               = cpu_run_q;
    assign Rx_Ovr_Err            = ovr_q;

endmodule

// File: tb/tb_icache_uart_loader.sv
// Randomized bench for icache_uart_loader: transaction-level model of cache loads
// and dumps, with a BRAM stand-in and a per-cycle compare process.
module tb_icache_uart_loader;

    localparam int unsigned NL = 64;

    logic         Clk = 1'b0;
    logic         Resetb;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic [127:0] back_data;
    logic         cache_init;
    logic         send_back;
    logic         we;
    logic [5:0]   init_addr;
    logic [127:0] init_data;
    logic [5:0]   rd_addr;
    logic         cpu_run;
    logic         ovr_err;

    icache_uart_loader dut (
        .Clk                   (Clk),
        .Resetb                (Resetb),
        .Rx_Valid              (rx_valid),
        .Rx_Data               (rx_data),
        .Tx_Ready              (tx_ready),
        .Tx_Valid              (tx_valid),
        .Tx_Data               (tx_data),
        .InstCache_BackData    (back_data),
        .Cache_Init            (cache_init),
        .Send_DataBack         (send_back),
        .Uart_InstCache_WE     (we),
        .Uart_Cache_InitAddr   (init_addr),
        .Uart_Cache_InitData   (init_data),
        .Uart_InstCache_RdAddr (rd_addr),
        .Cpu_Run               (cpu_run),
        .Rx_Ovr_Err            (ovr_err)
    );

    initial forever #5 Clk = ~Clk;

    // BRAM stand-in with one-cycle read latency
    logic [127:0] bram [NL];
    always @(posedge Clk) begin
        if (we) bram[init_addr] <= init_data;
        back_data <= bram[rd_addr];
    end

    // Model state
    logic [127:0] exp_mem [NL];
    logic [127:0] line_acc;
    int           byte_in_line;
    int           line_idx;
    bit           loaded_m;
    bit           ovr_m;
    logic [133:0] wr_q [$];
    logic [7:0]   tx_q [$];

    int           n_cmp = 0;
    int           n_bad = 0;
    int           ready_mode = 0;
    int           gap_cnt;
    int           we_cnt;
    int           tx_cnt;
    logic [127:0] line0_seen;
    logic [127:0] line63_seen;
    logic [7:0]   tx300_seen;
    logic         prev_v;
    logic         prev_r;
    logic [7:0]   prev_d;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        byte_in_line = 0;
        line_idx     = 0;
        line_acc     = '0;
        loaded_m     = 1'b0;
        ovr_m        = 1'b0;
        wr_q.delete();
        tx_q.delete();
    endtask

    task automatic model_load_byte(input logic [7:0] b);
        line_acc[8*byte_in_line +: 8] = b;
        byte_in_line++;
        if (byte_in_line == 16) begin
            exp_mem[line_idx] = line_acc;
            wr_q.push_back({6'(line_idx), line_acc});
            line_idx++;
            byte_in_line = 0;
            if (line_idx == int'(NL)) loaded_m = 1'b1;
        end
    endtask

    // All drive tasks start and end at posedge+1
    task automatic drive_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge Clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic illegal_cmd(input logic [7:0] b);
        drive_rx(b);
        idle(1);
        @(negedge Clk);
        chk("illegal_no_strobe", 128'({cache_init, send_back, we, tx_valid}), 128'(0));
        chk("illegal_cpu_run", 128'(cpu_run), 128'(loaded_m));
        @(posedge Clk); #1;
    endtask

    task automatic load(input bit rnd, input int nbytes, input int gapmax);
        byte_in_line = 0;
        line_idx     = 0;
        loaded_m     = 1'b0;
        drive_rx(8'hA5);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : 8'(i);
            model_load_byte(b);
            drive_rx(b);
            if (i != nbytes - 1) idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic load_finish_checks();
        @(negedge Clk);
        chk("last_we", 128'(we), 128'(1));
        chk("init_during_last_we", 128'(cache_init), 128'(1));
        chk("run_during_last_we", 128'(cpu_run), 128'(0));
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("run_after_load", 128'(cpu_run), 128'(1));
        chk("init_after_load", 128'(cache_init), 128'(0));
        chk("wr_queue_drained", 128'(wr_q.size()), 128'(0));
        @(posedge Clk); #1;
    endtask

    task automatic dump(input int mode, input bit inject);
        int  cyc;
        bit  injected;
        for (int l = 0; l < int'(NL); l++)
            for (int k = 0; k < 16; k++)
                tx_q.push_back(exp_mem[l][8*k +: 8]);
        gap_cnt    = 0;
        tx_cnt     = 0;
        ready_mode = mode;
        injected   = 1'b0;
        cyc        = 0;
        drive_rx(8'h5A);
        while (tx_q.size() != 0 && cyc < 20000) begin
            if (inject && !injected && tx_q.size() == 600) begin
                injected = 1'b1;
                ovr_m    = 1'b1;
                drive_rx(8'hA5);
                @(negedge Clk);
                chk("ovr_set", 128'(ovr_err), 128'(1));
                @(posedge Clk); #1;
                cyc += 2;
            end else begin
                @(posedge Clk); #1;
                cyc++;
            end
        end
        chk("dump_done", 128'(tx_q.size()), 128'(0));
        @(negedge Clk);
        chk("sdb_after_dump", 128'({send_back, tx_valid}), 128'(0));
        chk("run_after_dump", 128'(cpu_run), 128'(loaded_m));
        chk("dump_gap_cycles", 128'(gap_cnt), 128'(2 * NL));
        chk("dump_tx_count", 128'(tx_cnt), 128'(16 * NL));
        chk("ovr_after_dump", 128'(ovr_err), 128'(ovr_m));
        @(posedge Clk); #1;
        ready_mode = 0;
    endtask

    // Ready pattern generator
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge Clk); #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Per-cycle compare against the model streams and handshake rules
    always @(negedge Clk) begin
        if (!Resetb) begin
            prev_v <= 1'b0;
        end else begin
            if (prev_v && !prev_r)
                chk("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, prev_d}));
            if (we) begin
                we_cnt++;
                chk("we_with_init", 128'(cache_init), 128'(1));
                if (wr_q.size() == 0) begin
                    chk("we_expected", 128'(wr_q.size()), 128'(1));
                end else begin
                    logic [133:0] w;
                    w = wr_q.pop_front();
                    chk("we_addr", 128'(init_addr), 128'(w[133:128]));
                    chk("we_data", init_data, w[127:0]);
                end
                if (init_addr == 6'd0)  line0_seen  = init_data;
                if (init_addr == 6'd63) line63_seen = init_data;
            end
            if (tx_valid && tx_ready) begin
                if (tx_cnt == 300) tx300_seen = tx_data;
                tx_cnt++;
                if (tx_q.size() == 0) begin
                    chk("tx_expected", 128'(tx_q.size()), 128'(1));
                end else begin
                    chk("tx_byte", 128'(tx_data), 128'(tx_q.pop_front()));
                end
            end
            if (send_back && !tx_valid) gap_cnt++;
            if (tx_valid) chk("valid_in_dump", 128'(send_back), 128'(1));
            if (cache_init || send_back) chk("cpu_run_gated", 128'(cpu_run), 128'(0));
            prev_v <= tx_valid;
            prev_r <= tx_ready;
            prev_d <= tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        Resetb   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        we_cnt   = 0;
        tx_cnt   = 0;
        gap_cnt  = 0;
        model_reset();
        idle(3);
        chk("reset_flags", 128'({cache_init, send_back, we, tx_valid, cpu_run, ovr_err}), 128'(0));
        chk("reset_buses", 128'({init_addr, rd_addr, tx_data}), 128'(0));
        chk("reset_data", init_data, 128'(0));
        Resetb = 1'b1;
        idle(2);

        illegal_cmd(8'h00);
        illegal_cmd(8'hFF);

        // Abort a load at line 10 byte 7
        load(1'b0, 10 * 16 + 8, 0);
        idle(1);
        Resetb = 1'b0;
        #1;
        chk("midload_reset_flags", 128'({cache_init, send_back, we, tx_valid, cpu_run, ovr_err}), 128'(0));
        chk("midload_reset_addr", 128'(init_addr), 128'(0));
        chk("midload_wr_count", 128'(wr_q.size()), 128'(0));
        model_reset();
        idle(2);
        Resetb = 1'b1;
        idle(2);

        // Full incrementing load, bytes back-to-back
        we_cnt = 0;
        load(1'b0, 16 * NL, 0);
        load_finish_checks();
        chk("line0_model", exp_mem[0], 128'h0F0E0D0C0B0A09080706050403020100);
        chk("line63_model", exp_mem[63], 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        chk("line0_dut", line0_seen, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("line63_dut", line63_seen, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        chk("we_count", 128'(we_cnt), 128'(64));

        illegal_cmd(8'h00);

        // Dump with toggling ready and one overrun byte
        dump(1, 1'b1);
        chk("tx_byte300", 128'(tx300_seen), 128'(8'h2C));
        idle(3);
        chk("ovr_sticky", 128'(ovr_err), 128'(1));

        // Random data with random gaps, random ready
        load(1'b1, 16 * NL, 3);
        load_finish_checks();
        dump(2, 1'b0);

        // Reset clears the loaded flag and overrun; dump before any load
        Resetb = 1'b0;
        #1;
        chk("reset2_ovr", 128'({ovr_err, cpu_run}), 128'(0));
        loaded_m = 1'b0;
        ovr_m    = 1'b0;
        idle(2);
        Resetb = 1'b1;
        idle(2);
        dump(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_uart_loader.md
# icache_uart_loader

UART-side sequencer for the instruction cache's BRAM body. It loads the whole instruction memory from a host byte stream and later dumps it back through the UART transmitter. It drives the cache's initialization and readback mux selects, write enable, addresses and 128-bit write data. It also gates CPU execution (`Cpu_Run`) so the processor never fetches from a partially loaded cache.

## Interface
- `NUM_LINES`, 64: cache lines; address width is fixed at 6 bits.
- `CMD_LOAD`, 8'hA5: host command byte that starts a load.
- `CMD_DUMP`, 8'h5A: host command byte that starts a dump.

Ports:
- `Clk` in 1: UART-domain clock.
- `Resetb` in 1: reset, asynchronous, active-low; clock `Clk`.
- `Rx_Valid` in 1: one-cycle strobe; `Rx_Data` is valid.
- `Rx_Data` in 8: received byte.
- `Tx_Ready` in 1: transmitter can accept a byte.
- `Tx_Valid` out 1: `Tx_Data` is valid; held until handshake.
- `Tx_Data` out 8: byte to transmit.
- `InstCache_BackData` in 128: cache BRAM read data; 1-cycle latency from `Uart_InstCache_RdAddr`.
- `Cache_Init` out 1: load in progress; selects the UART clock/write path.
- `Send_DataBack` out 1: dump in progress; selects the UART read address.
- `Uart_InstCache_WE` out 1: one-cycle BRAM write strobe.
- `Uart_Cache_InitAddr` out 6: write line address.
- `Uart_Cache_InitData` out 128: write line data.
- `Uart_InstCache_RdAddr` out 6: read line address.
- `Cpu_Run` out 1: a load has completed and no command is active.
- `Rx_Ovr_Err` out 1: sticky; a byte arrived in a state that cannot accept it.

## Operation
States: IDLE, LOAD, DUMP_RD, DUMP_CAP, DUMP_TX.

- **IDLE**
  - `Rx_Valid` with `CMD_LOAD`: go to LOAD. Clear line counter and byte counter. `Cache_Init`=1, `Cpu_Run`=0.
  - `Rx_Valid` with `CMD_DUMP`: go to DUMP_RD. Clear line counter. `Send_DataBack`=1, `Cpu_Run`=0.
  - Any other byte is ignored.
- **LOAD**
  - Each `Rx_Valid` shifts the byte into the assembly register. The first byte of a line becomes bits [7:0]; byte k becomes bits [8k+7:8k].
  - Byte counter is 4 bits and wraps 15→0.
  - On byte 15:
    - the assembled line is copied to `Uart_Cache_InitData`;
    - `Uart_Cache_InitAddr` = line counter;
    - `Uart_InstCache_WE` pulses for exactly the next cycle;
    - line counter increments.
  - The assembly register accepts the next line's first byte in the same cycle as the WE pulse.
  - After line `NUM_LINES`-1 is written: return to IDLE, `Cache_Init`=0, and set the loaded flag (`Cpu_Run`=1).
- **DUMP_RD**: `Uart_InstCache_RdAddr` = line counter; go to DUMP_CAP next cycle.
- **DUMP_CAP**: capture `InstCache_BackData` into the TX shift register; byte index=0; go to DUMP_TX.
- **DUMP_TX**
  - `Tx_Valid`=1, `Tx_Data` = bits [7:0] of the shift register.
  - On `Tx_Valid`&&`Tx_Ready`: shift right 8 and increment the byte index.
  - After byte 15 is accepted:
    - if the line counter is `NUM_LINES`-1, return to IDLE with `Send_DataBack`=0;
    - otherwise increment the line counter and go to DUMP_RD.
- **Dump completion:** `Cpu_Run` is restored to the loaded flag when a dump completes.
- **Rx bytes outside LOAD and IDLE:** any `Rx_Valid` in DUMP_* sets `Rx_Ovr_Err` and the byte is dropped. Only reset clears `Rx_Ovr_Err`.
- **Dump before any load** is legal. It returns whatever the BRAM holds.

## Timing
- **Reset values**:
  - all outputs 0;
  - state IDLE;
  - loaded flag 0;
  - counters 0.
- **Reset mid-load or mid-dump** aborts immediately:
  - `Cache_Init`, `Send_DataBack`, `Uart_InstCache_WE` and `Tx_Valid` drop asynchronously;
  - the loaded flag is cleared, so `Cpu_Run` is 0 until a full load completes.
- **Write timing:** `Uart_InstCache_WE` is high the cycle after the 16th byte's `Rx_Valid`. `Uart_Cache_InitAddr`/`Uart_Cache_InitData` are stable in that cycle. `Cache_Init` stays 1 through that cycle and drops the following cycle.
- **Read latency:** 2 cycles from entering DUMP_RD to the first `Tx_Valid` of that line.
- **Transmit handshake:**
  - `Tx_Valid`/`Tx_Data` stay constant while `Tx_Ready`=0;
  - `Tx_Valid` stays high between the bytes of a line;
  - `Tx_Valid` is 0 during DUMP_RD and DUMP_CAP.
- **Line counter** is 6 bits. The terminal comparison is against `NUM_LINES`-1, with no wrap past it.
- **Back-to-back `Rx_Valid`** on consecutive cycles in LOAD is accepted with no loss.

## Test plan
- **Full load:** reset, send A5 then 1024 bytes where byte n = n[7:0].
  - Line 0 data = 128'h0F0E…0100 and line 63 = 128'hFFFE…F1F0.
  - Exactly 64 WE pulses at addresses 0..63.
  - `Cpu_Run` rises one cycle after the last WE.
- **Dump:** after the load, send 5A with `Tx_Ready` toggling 1/0.
  - 1024 bytes transmitted equal 00..FF repeating.
  - `Send_DataBack` is 1 throughout and falls after the last handshake.
  - `Cpu_Run` is 0 during the dump and 1 after it.
- **Illegal commands:** send 00 and FF in IDLE → no state change, no strobes.
- **Reset mid-load:** assert `Resetb`=0 after line 10 byte 7 → all outputs 0. A new A5 load then starts at address 0.
- **Overrun:** send a byte while in DUMP_TX → `Rx_Ovr_Err`=1 and stays 1. The dump data is unaffected.
- **Back-to-back bytes:** `Rx_Valid` on 16 consecutive cycles → one WE with correct data, and the next byte is accepted during the WE cycle.
